park_lot_controller: RTL and testbench
======================================

# park_lot_controller

Sequential allocator for the 8-space parking lot. Tracks occupancy, services arrival requests one at a time with a request/acknowledge handshake, and assigns the highest-numbered free space, matching the lot's space-number priority rule. Processes departures on any cycle. It sits between the gate sensors/entry logic and the display/barrier logic, and owns the authoritative occupancy vector.

## Interface
- `STATS_WIDTH`, default 8: width of the optional statistics counters.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `enable`  in  1  allocation enable; when low, arrivals are not serviced, but departures still are.
- `arrive_req`  in  1  car at entry gate; level, held until `arrive_ack` or `arrive_nack` is seen.
- `leave_valid`  in  1  single-cycle departure strobe.
- `leave_number`  in  3  space being vacated; qualified by `leave_valid`.
- `arrive_ack`  out  1  one-cycle grant pulse.
- `arrive_nack`  out  1  one-cycle reject pulse when the lot is full.
- `park_number`  out  3  granted space; valid only while `arrive_ack`=1, otherwise 0.
- `space_status`  out  8  occupancy vector; bit i=1 means space i is occupied.
- `free_count`  out  4  number of free spaces, 0..8.
- `full`  out  1  `space_status`==8'hFF.
- `leave_error`  out  1  one-cycle pulse when a departure names a space that is not occupied.

## Operation
- FSM states: IDLE, SEARCH, GRANT, REJECT, WAIT_DROP.
- IDLE: if `enable` && `arrive_req`, go to SEARCH. Otherwise stay in IDLE.
- SEARCH: register `sel` = index of the highest 0 bit of `space_status`.
  - If `full`, go to REJECT.
  - Otherwise go to GRANT.
  - `enable` is ignored once the FSM has left IDLE.
- GRANT: `arrive_ack`=1 and `park_number`=`sel`. At the exit edge, set `space_status[sel]` and go to WAIT_DROP.
- REJECT: `arrive_nack`=1. Occupancy is unchanged. Go to WAIT_DROP.
- WAIT_DROP: stay until `arrive_req`=0, then go to IDLE. This guarantees exactly one grant per request.
- Departures (any state):
  - If `leave_valid` && `space_status[leave_number]`, clear that bit at the next edge.
  - If the bit is already 0, pulse `leave_error` the next cycle and leave occupancy unchanged.
- Simultaneous events in one cycle: next occupancy = (occ | grant_mask) & ~leave_mask.
  - `leave_mask` is qualified by the current occupancy.
  - A departure naming the space being granted in that GRANT cycle is therefore an error. The space still becomes occupied.
  - A departure during SEARCH or GRANT does not change `sel`; the snapshot is taken in SEARCH.
- `free_count` = 8 − popcount(`space_status`), updated combinationally from the register.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `space_status`=0, `free_count`=8, `full`=0.
  - `arrive_ack`, `arrive_nack`, `park_number` and `leave_error` are all 0.
  - Statistics counters go to 0.
  - Reset mid-handshake aborts the handshake, and no occupancy is recorded.
- Arrival latency: `arrive_req` sampled high at edge k gives SEARCH after k, and GRANT or REJECT after k+1.
  - `arrive_ack`/`arrive_nack` is high for exactly the cycle between edges k+1 and k+2.
  - `space_status` shows the new bit after edge k+2.
- Departure latency: `leave_valid` at edge k updates `space_status`, or raises `leave_error`, after edge k.
- Minimum request-to-request spacing is 4 cycles (IDLE, SEARCH, GRANT, WAIT_DROP with `arrive_req` low).
- All outputs except `free_count`/`full` are registered; `free_count` and `full` are decoded from registers.

## Configuration
- `PARK_STATS_EN` defined:
  - Adds output `entry_count` [STATS_WIDTH-1:0], incremented on each GRANT exit.
  - Adds output `reject_count` [STATS_WIDTH-1:0], incremented on each REJECT exit.
  - Both counters wrap modulo 2^STATS_WIDTH and are cleared by reset.
- `PARK_STATS_EN` undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then `arrive_req`=1 with `enable`=1 -> `arrive_ack` pulse 2 cycles later with `park_number`=7; after release, `space_status`=8'h80 and `free_count`=7.
- Eight sequential arrivals -> grants of 7,6,5,4,3,2,1,0; `full`=1. A ninth arrival -> `arrive_nack` pulse, and `space_status` stays 8'hFF.
- From full, `leave_valid` with `leave_number`=4, then one arrival -> `space_status`=8'hEF, then the grant is `park_number`=4.
- `leave_valid` with `leave_number`=2 on an empty lot -> `leave_error` for one cycle, `space_status` stays 0. Departure of space 5 in the same cycle as a grant of space 3 (with 7,6,5,4 occupied) -> `space_status` becomes 8'hD8.
- `enable`=0 with `arrive_req` held for 10 cycles -> no ack. Raise `enable` -> ack 2 cycles later. `arrive_req` held high for 5 cycles after ack -> exactly one grant.
- `rst_n`=0 during GRANT -> next cycle all outputs are 0 and `free_count`=8. With `PARK_STATS_EN` and STATS_WIDTH=2, five grants -> `entry_count`=1.

Source files
------------

// File: rtl/park_lot_controller_if.sv
// Gate-side bus of the parking-lot allocator: arrival handshake, departure strobe and occupancy readout.
// master = entry/gate logic, slave = park_lot_controller.
interface park_lot_if;
  logic       enable;
  logic       arrive_req;
  logic       leave_valid;
  logic [2:0] leave_number;
  logic       arrive_ack;
  logic       arrive_nack;
  logic [2:0] park_number;
  logic [7:0] space_status;
  logic [3:0] free_count;
  logic       full;
  logic       leave_error;

  modport master (
    output enable, arrive_req, leave_valid, leave_number,
    input  arrive_ack, arrive_nack, park_number, space_status, free_count, full, leave_error
  );

  modport slave (
    input  enable, arrive_req, leave_valid, leave_number,
    output arrive_ack, arrive_nack, park_number, space_status, free_count, full, leave_error
  );
endinterface

// File: rtl/park_lot_controller.sv
// 8-space parking-lot allocator: one arrival at a time via req/ack, highest free space first, departures any cycle.
// Optional statistics counters (entry_count/reject_count) are built only when PARK_STATS_EN is defined.
module park_lot_controller #(
  parameter int STATS_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  park_lot_if.slave bus
`ifdef PARK_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] entry_count,
  output logic [STATS_WIDTH-1:0] reject_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_GRANT, S_REJECT, S_WAIT_DROP
  } state_e;

  if (STATS_WIDTH < 1) begin : g_bad_width
    $error("STATS_WIDTH must be at least 1");
  end

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] occ_q, occ_d;
  logic       ack_q, ack_d;
  logic       nack_q, nack_d;
  logic [2:0] park_q, park_d;
  logic       lerr_q, lerr_d;
  logic [2:0] highest_free;
  logic [3:0] occ_pop;
  logic       occ_full;
  logic [7:0] grant_mask, leave_mask;

  // Last hit wins, so the loop leaves the highest-numbered free space in highest_free.
  always_comb begin
    highest_free = 3'd0;
    occ_pop      = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (!occ_q[i]) highest_free = 3'(i);
      occ_pop = occ_pop + {3'b000, occ_q[i]};
    end
  end

  assign occ_full = &occ_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE:      if (bus.enable && bus.arrive_req) state_d = S_SEARCH;
      S_SEARCH: begin
        sel_d   = highest_free;
        state_d = occ_full ? S_REJECT : S_GRANT;
      end
      S_GRANT:     state_d = S_WAIT_DROP;
      S_REJECT:    state_d = S_WAIT_DROP;
      S_WAIT_DROP: if (!bus.arrive_req) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered, so they are derived from the state being entered.
  always_comb begin
    ack_d  = (state_d == S_GRANT);
    nack_d = (state_d == S_REJECT);
    park_d = ack_d ? sel_d : 3'd0;
  end

  // Departures are qualified by current occupancy; a grant and a departure may land on the same edge.
  always_comb begin
    grant_mask = (state_q == S_GRANT) ? (8'd1 << sel_q) : 8'd0;
    leave_mask = (bus.leave_valid && occ_q[bus.leave_number]) ? (8'd1 << bus.leave_number) : 8'd0;
    occ_d      = (occ_q | grant_mask) & ~leave_mask;
    lerr_d     = bus.leave_valid && !occ_q[bus.leave_number];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= 3'd0;
      occ_q  <= 8'd0;
      ack_q  <= 1'b0;
      nack_q <= 1'b0;
      park_q <= 3'd0;
      lerr_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      occ_q  <= occ_d;
      ack_q  <= ack_d;
      nack_q <= nack_d;
      park_q <= park_d;
      lerr_q <= lerr_d;
    end
  end

`ifdef PARK_STATS_EN
  logic [STATS_WIDTH-1:0] entry_q, reject_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q  <= '0;
      reject_q <= '0;
    end else begin
      if (state_q == S_GRANT)  entry_q  <= entry_q + 1'b1;
      if (state_q == S_REJECT) reject_q <= reject_q + 1'b1;
    end
  end

  assign entry_count  = entry_q;
  assign reject_count = reject_q;
`endif

  assign bus.arrive_ack   = ack_q;
  assign bus.arrive_nack  = nack_q;
  assign bus.park_number  = park_q;
  assign bus.space_status = occ_q;
  assign bus.free_count   = 4'd8 - occ_pop;
  assign bus.full        = occ_full;
  assign bus.leave_error  = lerr_q;

endmodule

// File: tb/tb_park_lot_controller.sv
// Self-checking bench for park_lot_controller: directed scenarios plus randomized traffic against a lot model.
module tb_park_lot_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  park_lot_if bus();

`ifdef PARK_STATS_EN
  logic [1:0] entry_count, reject_count;
`endif

  park_lot_controller #(
`ifdef PARK_STATS_EN
    .STATS_WIDTH(2)
`else
    .STATS_WIDTH(8)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PARK_STATS_EN
    ,
    .entry_count  (entry_count),
    .reject_count (reject_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Lot model: one flag per space.
  bit model_occ [8];

  function automatic int model_highest_free();
    for (int i = 7; i >= 0; i--) if (!model_occ[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = model_occ[i];
    return v;
  endfunction

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < 8; i++) if (!model_occ[i]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model_occ[i] = 1'b0;
  endtask

  // Raise arrive_req, wait for ack/nack (bounded), release, and wait until the FSM is back in IDLE.
  task automatic arrive(output bit ack, output bit nack, output logic [2:0] pn, output int lat);
    ack = 0; nack = 0; pn = 3'd0; lat = 0;
    bus.arrive_req = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.arrive_ack || bus.arrive_nack) begin
        ack  = bus.arrive_ack;
        nack = bus.arrive_nack;
        pn   = bus.park_number;
        lat  = i;
        break;
      end
    end
    bus.arrive_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.arrive_req = 1'b0; bus.leave_valid = 1'b0; bus.leave_number = 3'd0;
    do_reset();
    checks++;
    if (bus.space_status !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", bus.space_status); end
    checks++;
    if (bus.free_count !== 4'd8 || bus.full !== 1'b0) begin
      errors++; $display("FAIL reset_free got=%0d/%b exp=8/0", bus.free_count, bus.full);
    end
    checks++;
    if ({bus.arrive_ack, bus.arrive_nack, bus.park_number, bus.leave_error} !== 6'd0) begin
      errors++; $display("FAIL reset_pulses got=%b%b%0d%b exp=0000", bus.arrive_ack, bus.arrive_nack, bus.park_number, bus.leave_error);
    end
    $display("reset: status=%h free=%0d", bus.space_status, bus.free_count);
  endtask

  task automatic test_first_grant();
    bit a, n; logic [2:0] pn; int lat;
    arrive(a, n, pn, lat);
    model_occ[7] = 1'b1;
    checks++;
    if (!(a && !n && pn === 3'd7 && lat == 2)) begin
      errors++; $display("FAIL first_grant got ack=%b nack=%b pn=%0d lat=%0d exp ack=1 nack=0 pn=7 lat=2", a, n, pn, lat);
    end
    checks++;
    if (bus.space_status !== 8'h80 || bus.free_count !== 4'd7) begin
      errors++; $display("FAIL first_status got=%h/%0d exp=80/7", bus.space_status, bus.free_count);
    end
    $display("arrive: ack=%b pn=%0d lat=%0d status=%h", a, pn, lat, bus.space_status);
  endtask

  task automatic test_fill_and_reject();
    bit a, n; logic [2:0] pn; int lat; int exp_pn;
    for (int k = 0; k < 7; k++) begin
      exp_pn = model_highest_free();
      arrive(a, n, pn, lat);
      model_occ[exp_pn] = 1'b1;
      checks++;
      if (!(a && !n && pn === 3'(exp_pn) && lat == 2)) begin
        errors++; $display("FAIL fill_grant got ack=%b pn=%0d lat=%0d exp ack=1 pn=%0d lat=2", a, pn, lat, exp_pn);
      end
      $display("arrive: ack=%b pn=%0d status=%h", a, pn, bus.space_status);
    end
    checks++;
    if (bus.full !== 1'b1 || bus.space_status !== 8'hFF || bus.free_count !== 4'd0) begin
      errors++; $display("FAIL fill_full got=%b/%h/%0d exp=1/FF/0", bus.full, bus.space_status, bus.free_count);
    end
    arrive(a, n, pn, lat);
    checks++;
    if (!(!a && n && lat == 2 && bus.space_status === 8'hFF)) begin
      errors++; $display("FAIL reject got ack=%b nack=%b lat=%0d status=%h exp ack=0 nack=1 lat=2 status=FF", a, n, lat, bus.space_status);
    end
    $display("arrive: nack=%b status=%h", n, bus.space_status);
  endtask

  task automatic test_leave_then_arrive();
    bit a, n; logic [2:0] pn; int lat;
    bus.leave_valid = 1'b1; bus.leave_number = 3'd4;
    tick();
    bus.leave_valid = 1'b0;
    model_occ[4] = 1'b0;
    checks++;
    if (bus.space_status !== 8'hEF || bus.leave_error !== 1'b0) begin
      errors++; $display("FAIL leave4 got=%h err=%b exp=EF err=0", bus.space_status, bus.leave_error);
    end
    arrive(a, n, pn, lat);
    model_occ[4] = 1'b1;
    checks++;
    if (!(a && pn === 3'd4)) begin errors++; $display("FAIL regrant4 got ack=%b pn=%0d exp ack=1 pn=4", a, pn); end
    $display("leave 4 then arrive: pn=%0d status=%h", pn, bus.space_status);
  endtask

  task automatic test_leave_error_and_simultaneous();
    bit a, n; logic [2:0] pn; int lat;
    do_reset();
    bus.leave_valid = 1'b1; bus.leave_number = 3'd2;
    tick();
    bus.leave_valid = 1'b0;
    checks++;
    if (bus.leave_error !== 1'b1 || bus.space_status !== 8'h00) begin
      errors++; $display("FAIL leave_err got err=%b status=%h exp err=1 status=00", bus.leave_error, bus.space_status);
    end
    tick();
    checks++;
    if (bus.leave_error !== 1'b0) begin errors++; $display("FAIL leave_err_pulse got=%b exp=0", bus.leave_error); end
    for (int k = 0; k < 4; k++) begin
      arrive(a, n, pn, lat);
      model_occ[7 - k] = 1'b1;
    end
    // Grant of 3 while space 5 departs in the GRANT cycle.
    bus.arrive_req = 1'b1;
    tick(); tick();
    checks++;
    if (bus.arrive_ack !== 1'b1 || bus.park_number !== 3'd3) begin
      errors++; $display("FAIL simul_grant got ack=%b pn=%0d exp ack=1 pn=3", bus.arrive_ack, bus.park_number);
    end
    bus.leave_valid = 1'b1; bus.leave_number = 3'd5;
    tick();
    bus.leave_valid = 1'b0; bus.arrive_req = 1'b0;
    model_occ[3] = 1'b1; model_occ[5] = 1'b0;
    checks++;
    if (bus.space_status !== 8'hD8 || bus.leave_error !== 1'b0) begin
      errors++; $display("FAIL simul_status got=%h err=%b exp=D8 err=0", bus.space_status, bus.leave_error);
    end
    $display("grant 3 + leave 5: status=%h", bus.space_status);
    tick();
    // Departure naming the very space being granted: error, and the space still fills.
    bus.arrive_req = 1'b1;
    tick(); tick();
    bus.leave_valid = 1'b1; bus.leave_number = 3'd5;
    tick();
    bus.leave_valid = 1'b0; bus.arrive_req = 1'b0;
    model_occ[5] = 1'b1;
    checks++;
    if (bus.space_status !== 8'hF8 || bus.leave_error !== 1'b1) begin
      errors++; $display("FAIL same_space got=%h err=%b exp=F8 err=1", bus.space_status, bus.leave_error);
    end
    $display("grant 5 + leave 5: status=%h err=%b", bus.space_status, bus.leave_error);
    tick();
  endtask

  task automatic test_enable();
    int acks = 0; int lat = 0; int exp_pn;
    exp_pn = model_highest_free();
    bus.enable = 1'b0; bus.arrive_req = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.arrive_ack || bus.arrive_nack) acks++; end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL disabled_ack got=%0d exp=0", acks); end
    bus.enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.arrive_ack) begin lat = i; break; end
    end
    checks++;
    if (lat != 2 || bus.park_number !== 3'(exp_pn)) begin
      errors++; $display("FAIL enable_lat got lat=%0d pn=%0d exp lat=2 pn=%0d", lat, bus.park_number, exp_pn);
    end
    acks = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (bus.arrive_ack || bus.arrive_nack) acks++; end
    bus.arrive_req = 1'b0;
    tick(); tick();
    model_occ[exp_pn] = 1'b1;
    checks++;
    if (acks != 0 || bus.space_status !== model_vec()) begin
      errors++; $display("FAIL held_req got extra=%0d status=%h exp extra=0 status=%h", acks, bus.space_status, model_vec());
    end
    $display("enable: lat=%0d status=%h", lat, bus.space_status);
  endtask

  task automatic test_reset_mid_grant();
    bus.arrive_req = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    bus.arrive_req = 1'b0;
    checks++;
    if ({bus.arrive_ack, bus.arrive_nack, bus.park_number, bus.leave_error, bus.space_status} !== 14'd0
        || bus.free_count !== 4'd8 || bus.full !== 1'b0) begin
      errors++; $display("FAIL reset_grant got ack=%b pn=%0d status=%h free=%0d exp all 0 free=8",
                         bus.arrive_ack, bus.park_number, bus.space_status, bus.free_count);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model_occ[i] = 1'b0;
    tick();
    $display("reset in GRANT: status=%h free=%0d", bus.space_status, bus.free_count);
  endtask

`ifdef PARK_STATS_EN
  task automatic test_stats();
    bit a, n; logic [2:0] pn; int lat;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      arrive(a, n, pn, lat);
      model_occ[7 - k] = 1'b1;
    end
    checks++;
    if (entry_count !== 2'd1 || reject_count !== 2'd0) begin
      errors++; $display("FAIL stats got entry=%0d reject=%0d exp entry=1 reject=0", entry_count, reject_count);
    end
    $display("stats: entry=%0d reject=%0d", entry_count, reject_count);
  endtask
`endif

  task automatic test_random();
    int exp_hi; bit inject; logic [2:0] ln; bit exp_err; bit got_ack, got_nack; logic [2:0] got_pn;
    do_reset();
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        ln = 3'($urandom_range(0, 7));
        exp_err = !model_occ[ln];
        bus.leave_valid = 1'b1; bus.leave_number = ln;
        tick();
        bus.leave_valid = 1'b0;
        model_occ[ln] = 1'b0;
        checks++;
        if (bus.leave_error !== exp_err || bus.space_status !== model_vec()) begin
          errors++; $display("FAIL rnd_leave n=%0d got err=%b status=%h exp err=%b status=%h",
                             ln, bus.leave_error, bus.space_status, exp_err, model_vec());
        end
        $display("rnd leave %0d: err=%b status=%h", ln, bus.leave_error, bus.space_status);
      end else begin
        // The chosen space is fixed by the occupancy seen when the request is taken.
        exp_hi = model_highest_free();
        inject = ($urandom_range(0, 1) == 1);
        ln = 3'($urandom_range(0, 7));
        exp_err = 1'b0;
        bus.arrive_req = 1'b1;
        tick();
        if (inject) begin
          bus.leave_valid = 1'b1; bus.leave_number = ln;
          exp_err = !model_occ[ln];
        end
        tick();
        bus.leave_valid = 1'b0;
        got_ack = bus.arrive_ack; got_nack = bus.arrive_nack; got_pn = bus.park_number;
        if (inject) model_occ[ln] = 1'b0;
        checks++;
        if (exp_hi < 0) begin
          if (!(got_nack && !got_ack && got_pn === 3'd0 && bus.leave_error === exp_err)) begin
            errors++; $display("FAIL rnd_arrive got ack=%b nack=%b err=%b exp nack err=%b", got_ack, got_nack, bus.leave_error, exp_err);
          end
        end else begin
          if (!(got_ack && !got_nack && got_pn === 3'(exp_hi) && bus.leave_error === exp_err)) begin
            errors++; $display("FAIL rnd_arrive got ack=%b nack=%b pn=%0d err=%b exp ack pn=%0d err=%b",
                               got_ack, got_nack, got_pn, bus.leave_error, exp_hi, exp_err);
          end
          model_occ[exp_hi] = 1'b1;
        end
        bus.arrive_req = 1'b0;
        tick(); tick();
        checks++;
        if (bus.space_status !== model_vec() || bus.free_count !== 4'(model_free())) begin
          errors++; $display("FAIL rnd_status got=%h/%0d exp=%h/%0d", bus.space_status, bus.free_count, model_vec(), model_free());
        end
        $display("rnd arrive: ack=%b nack=%b pn=%0d status=%h", got_ack, got_nack, got_pn, bus.space_status);
      end
    end
  endtask

  initial begin
    bus.enable = 1'b1; bus.arrive_req = 1'b0; bus.leave_valid = 1'b0; bus.leave_number = 3'd0;
    test_reset();
    test_first_grant();
    test_fill_and_reject();
    test_leave_then_arrive();
    test_leave_error_and_simultaneous();
    test_enable();
    test_reset_mid_grant();
`ifdef PARK_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
